// File: rtl/vfu_pkg.sv
// Shared types and widths for the vector functional-unit issue logic.
package vfu_pkg;

    localparam int ELEN = 32;
    localparam int REGW = 5;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_MUL = 1'b1
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/vfu_beat_tracker.sv
// Delay line carrying beat valid/last/idx/mask from the read cycle to the write cycle.
// Stage 0 lines up with returning read data, the final stage with the FU result.
module vfu_beat_tracker #(
    parameter int DEPTH = 2,
    parameter int LANES = 1,
    parameter int IDXW  = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_last,
    input  logic [IDXW-1:0]  in_idx,
    input  logic [LANES-1:0] in_mask,
    output logic             op_valid,
    output logic [LANES-1:0] op_mask,
    output logic             out_valid,
    output logic             out_last,
    output logic [IDXW-1:0]  out_idx,
    output logic [LANES-1:0] out_mask
);

    logic [DEPTH-1:0]            valid_reg;
    logic [DEPTH-1:0]            last_reg;
    logic [DEPTH-1:0][IDXW-1:0]  idx_reg;
    logic [DEPTH-1:0][LANES-1:0] mask_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg <= '0;
            last_reg  <= '0;
            idx_reg   <= '0;
            mask_reg  <= '0;
        end else begin
            valid_reg[0] <= in_valid;
            last_reg[0]  <= in_valid && in_last;
            idx_reg[0]   <= in_idx;
            mask_reg[0]  <= in_valid ? in_mask : '0;
            for (int i = 1; i < DEPTH; i++) begin
                valid_reg[i] <= valid_reg[i-1];
                last_reg[i]  <= last_reg[i-1];
                idx_reg[i]   <= idx_reg[i-1];
                mask_reg[i]  <= mask_reg[i-1];
            end
        end
    end

    assign op_valid  = valid_reg[0];
    assign op_mask   = mask_reg[0];
    assign out_valid = valid_reg[DEPTH-1];
    assign out_last  = last_reg[DEPTH-1];
    assign out_idx   = idx_reg[DEPTH-1];
    assign out_mask  = mask_reg[DEPTH-1];

endmodule

// File: rtl/vector_issue_seq.sv
// Sequences one vector add/mul command into register-file read beats, FU operands
// and delayed write-back beats; one command in flight at a time.
module vector_issue_seq
    import vfu_pkg::*;
#(
    parameter int LANES  = 1,
    parameter int FU_LAT = 1,
    parameter int VLMAX  = 32,
    localparam int VLW   = $clog2(VLMAX) + 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_op,
    input  logic [VLW-1:0]             cmd_vl,
    input  logic [REGW-1:0]            cmd_vs1,
    input  logic [REGW-1:0]            cmd_vs2,
    input  logic [REGW-1:0]            cmd_vd,
    output logic                       rf_rd_en,
    output logic [REGW-1:0]            rf_rd_vs1,
    output logic [REGW-1:0]            rf_rd_vs2,
    output logic [VLW-1:0]             rf_rd_idx,
    input  logic [LANES-1:0][ELEN-1:0] rf_rd_data1,
    input  logic [LANES-1:0][ELEN-1:0] rf_rd_data2,
    output logic [LANES-1:0][ELEN-1:0] fu_add_a,
    output logic [LANES-1:0][ELEN-1:0] fu_add_b,
    input  logic [LANES-1:0][ELEN-1:0] fu_add_c,
    output logic [LANES-1:0][ELEN-1:0] fu_mul_a,
    output logic [LANES-1:0][ELEN-1:0] fu_mul_b,
    input  logic [LANES-1:0][ELEN-1:0] fu_mul_c,
    output logic                       rf_wr_en,
    output logic [REGW-1:0]            rf_wr_vd,
    output logic [VLW-1:0]             rf_wr_idx,
    output logic [LANES-1:0]           rf_wr_mask,
    output logic [LANES-1:0][ELEN-1:0] rf_wr_data,
    output logic                       done
);

    state_e          state_reg;
    op_e             op_reg;
    logic [VLW-1:0]  vl_reg;
    logic [REGW-1:0] vs1_reg, vs2_reg, vd_reg;
    logic            rd_en_reg;
    logic [VLW-1:0]  rd_idx_reg;
    logic            zero_done_reg;

    logic [VLW-1:0]   vl_in;
    logic             accept;
    logic             last_beat;
    logic [LANES-1:0] rd_mask;
    logic             op_valid, out_valid, out_last;
    logic [LANES-1:0] op_mask, out_mask;
    logic [VLW-1:0]   out_idx;

    assign cmd_ready = (state_reg == ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign vl_in     = (cmd_vl > VLW'(VLMAX)) ? VLW'(VLMAX) : cmd_vl;

    // One extra bit so idx+LANES cannot wrap when compared against vl.
    assign last_beat = ({1'b0, rd_idx_reg} + (VLW+1)'(LANES)) >= {1'b0, vl_reg};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            op_reg        <= OP_ADD;
            vl_reg        <= '0;
            vs1_reg       <= '0;
            vs2_reg       <= '0;
            vd_reg        <= '0;
            rd_en_reg     <= 1'b0;
            rd_idx_reg    <= '0;
            zero_done_reg <= 1'b0;
        end else begin
            zero_done_reg <= 1'b0;
            unique case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        op_reg     <= op_e'(cmd_op);
                        vl_reg     <= vl_in;
                        vs1_reg    <= cmd_vs1;
                        vs2_reg    <= cmd_vs2;
                        vd_reg     <= cmd_vd;
                        rd_idx_reg <= '0;
                        if (vl_in == '0) begin
                            zero_done_reg <= 1'b1;
                        end else begin
                            state_reg <= ST_ISSUE;
                            rd_en_reg <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (last_beat) begin
                        rd_en_reg <= 1'b0;
                        state_reg <= ST_DRAIN;
                    end else begin
                        rd_idx_reg <= rd_idx_reg + VLW'(LANES);
                    end
                end
                ST_DRAIN: begin
                    if (out_valid && out_last) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    vfu_beat_tracker #(
        .DEPTH (1 + FU_LAT),
        .LANES (LANES),
        .IDXW  (VLW)
    ) u_tracker (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (rd_en_reg),
        .in_last   (last_beat),
        .in_idx    (rd_idx_reg),
        .in_mask   (rd_mask),
        .op_valid  (op_valid),
        .op_mask   (op_mask),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_idx   (out_idx),
        .out_mask  (out_mask)
    );

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic lane_on;
        assign rd_mask[gi]    = ({1'b0, rd_idx_reg} + (VLW+1)'(gi)) < {1'b0, vl_reg};
        assign lane_on        = op_valid && op_mask[gi];
        assign fu_add_a[gi]   = (lane_on && op_reg == OP_ADD) ? rf_rd_data1[gi] : '0;
        assign fu_add_b[gi]   = (lane_on && op_reg == OP_ADD) ? rf_rd_data2[gi] : '0;
        assign fu_mul_a[gi]   = (lane_on && op_reg == OP_MUL) ? rf_rd_data1[gi] : '0;
        assign fu_mul_b[gi]   = (lane_on && op_reg == OP_MUL) ? rf_rd_data2[gi] : '0;
        assign rf_wr_data[gi] = (op_reg == OP_MUL) ? fu_mul_c[gi] : fu_add_c[gi];
    end

    assign rf_rd_en   = rd_en_reg;
    assign rf_rd_vs1  = vs1_reg;
    assign rf_rd_vs2  = vs2_reg;
    assign rf_rd_idx  = rd_idx_reg;
    assign rf_wr_en   = out_valid;
    assign rf_wr_vd   = vd_reg;
    assign rf_wr_idx  = out_idx;
    assign rf_wr_mask = out_valid ? out_mask : '0;
    assign done       = (out_valid && out_last) || zero_done_reg;

endmodule

// File: tb/tb_vector_issue_seq.sv
// Directed bench: three sequencer instances (1 lane/lat 1, 4 lanes/lat 1, 1 lane/lat 3)
// each with a register-file and FU model; expected values computed by hand.
module tb_vector_issue_seq;

    logic clk;
    logic rst;
    logic init_rf;

    logic       cmd_op;
    logic [5:0] cmd_vl;
    logic [4:0] cmd_vs1, cmd_vs2, cmd_vd;
    logic       cmd_valid_a, cmd_valid_b, cmd_valid_c;

    int vectors = 0;
    int errors  = 0;

    // ---------------- instance A: LANES=1, FU_LAT=1 ----------------
    logic             cmd_ready_a, rf_rd_en_a, rf_wr_en_a, done_a;
    logic [4:0]       rf_rd_vs1_a, rf_rd_vs2_a, rf_wr_vd_a;
    logic [5:0]       rf_rd_idx_a, rf_wr_idx_a;
    logic [0:0]       rf_wr_mask_a;
    logic [0:0][31:0] rf_rd_data1_a, rf_rd_data2_a, fu_add_a_a, fu_add_b_a, fu_add_c_a;
    logic [0:0][31:0] fu_mul_a_a, fu_mul_b_a, fu_mul_c_a, rf_wr_data_a;
    logic [31:0]      rf_a [32][32];

    vector_issue_seq #(.LANES(1), .FU_LAT(1), .VLMAX(32)) dut_a (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid_a), .cmd_ready(cmd_ready_a),
        .cmd_op(cmd_op), .cmd_vl(cmd_vl), .cmd_vs1(cmd_vs1), .cmd_vs2(cmd_vs2), .cmd_vd(cmd_vd),
        .rf_rd_en(rf_rd_en_a), .rf_rd_vs1(rf_rd_vs1_a), .rf_rd_vs2(rf_rd_vs2_a), .rf_rd_idx(rf_rd_idx_a),
        .rf_rd_data1(rf_rd_data1_a), .rf_rd_data2(rf_rd_data2_a),
        .fu_add_a(fu_add_a_a), .fu_add_b(fu_add_b_a), .fu_add_c(fu_add_c_a),
        .fu_mul_a(fu_mul_a_a), .fu_mul_b(fu_mul_b_a), .fu_mul_c(fu_mul_c_a),
        .rf_wr_en(rf_wr_en_a), .rf_wr_vd(rf_wr_vd_a), .rf_wr_idx(rf_wr_idx_a),
        .rf_wr_mask(rf_wr_mask_a), .rf_wr_data(rf_wr_data_a), .done(done_a)
    );

    always @(posedge clk) begin
        if (init_rf) begin
            for (int r = 0; r < 32; r++)
                for (int e = 0; e < 32; e++)
                    rf_a[r][e] <= 32'(r * 16 + e);
        end else begin
            if (rf_rd_en_a) begin
                rf_rd_data1_a[0] <= rf_a[rf_rd_vs1_a][5'(int'(rf_rd_idx_a))];
                rf_rd_data2_a[0] <= rf_a[rf_rd_vs2_a][5'(int'(rf_rd_idx_a))];
            end
            if (rf_wr_en_a && rf_wr_mask_a[0])
                rf_a[rf_wr_vd_a][5'(int'(rf_wr_idx_a))] <= rf_wr_data_a[0];
        end
        fu_add_c_a[0] <= fu_add_a_a[0] + fu_add_b_a[0];
        fu_mul_c_a[0] <= fu_mul_a_a[0] * fu_mul_b_a[0];
    end

    // ---------------- instance B: LANES=4, FU_LAT=1 ----------------
    logic             cmd_ready_b, rf_rd_en_b, rf_wr_en_b, done_b;
    logic [4:0]       rf_rd_vs1_b, rf_rd_vs2_b, rf_wr_vd_b;
    logic [5:0]       rf_rd_idx_b, rf_wr_idx_b;
    logic [3:0]       rf_wr_mask_b;
    logic [3:0][31:0] rf_rd_data1_b, rf_rd_data2_b, fu_add_a_b, fu_add_b_b, fu_add_c_b;
    logic [3:0][31:0] fu_mul_a_b, fu_mul_b_b, fu_mul_c_b, rf_wr_data_b;
    logic [31:0]      rf_b [32][32];

    vector_issue_seq #(.LANES(4), .FU_LAT(1), .VLMAX(32)) dut_b (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
        .cmd_op(cmd_op), .cmd_vl(cmd_vl), .cmd_vs1(cmd_vs1), .cmd_vs2(cmd_vs2), .cmd_vd(cmd_vd),
        .rf_rd_en(rf_rd_en_b), .rf_rd_vs1(rf_rd_vs1_b), .rf_rd_vs2(rf_rd_vs2_b), .rf_rd_idx(rf_rd_idx_b),
        .rf_rd_data1(rf_rd_data1_b), .rf_rd_data2(rf_rd_data2_b),
        .fu_add_a(fu_add_a_b), .fu_add_b(fu_add_b_b), .fu_add_c(fu_add_c_b),
        .fu_mul_a(fu_mul_a_b), .fu_mul_b(fu_mul_b_b), .fu_mul_c(fu_mul_c_b),
        .rf_wr_en(rf_wr_en_b), .rf_wr_vd(rf_wr_vd_b), .rf_wr_idx(rf_wr_idx_b),
        .rf_wr_mask(rf_wr_mask_b), .rf_wr_data(rf_wr_data_b), .done(done_b)
    );

    always @(posedge clk) begin
        if (init_rf) begin
            for (int r = 0; r < 32; r++)
                for (int e = 0; e < 32; e++)
                    rf_b[r][e] <= 32'(r * 16 + e);
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (rf_rd_en_b) begin
                    rf_rd_data1_b[i] <= rf_b[rf_rd_vs1_b][5'(int'(rf_rd_idx_b) + i)];
                    rf_rd_data2_b[i] <= rf_b[rf_rd_vs2_b][5'(int'(rf_rd_idx_b) + i)];
                end
                if (rf_wr_en_b && rf_wr_mask_b[i])
                    rf_b[rf_wr_vd_b][5'(int'(rf_wr_idx_b) + i)] <= rf_wr_data_b[i];
            end
        end
        for (int i = 0; i < 4; i++) begin
            fu_add_c_b[i] <= fu_add_a_b[i] + fu_add_b_b[i];
            fu_mul_c_b[i] <= fu_mul_a_b[i] * fu_mul_b_b[i];
        end
    end

    // ---------------- instance C: LANES=1, FU_LAT=3 ----------------
    logic             cmd_ready_c, rf_rd_en_c, rf_wr_en_c, done_c;
    logic [4:0]       rf_rd_vs1_c, rf_rd_vs2_c, rf_wr_vd_c;
    logic [5:0]       rf_rd_idx_c, rf_wr_idx_c;
    logic [0:0]       rf_wr_mask_c;
    logic [0:0][31:0] rf_rd_data1_c, rf_rd_data2_c, fu_add_a_c, fu_add_b_c, fu_add_c_c;
    logic [0:0][31:0] fu_mul_a_c, fu_mul_b_c, fu_mul_c_c, rf_wr_data_c;
    logic [0:0][31:0] add_p1_c, add_p2_c;
    logic [31:0]      rf_c [32][32];

    assign fu_mul_c_c = '0;

    vector_issue_seq #(.LANES(1), .FU_LAT(3), .VLMAX(32)) dut_c (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid_c), .cmd_ready(cmd_ready_c),
        .cmd_op(cmd_op), .cmd_vl(cmd_vl), .cmd_vs1(cmd_vs1), .cmd_vs2(cmd_vs2), .cmd_vd(cmd_vd),
        .rf_rd_en(rf_rd_en_c), .rf_rd_vs1(rf_rd_vs1_c), .rf_rd_vs2(rf_rd_vs2_c), .rf_rd_idx(rf_rd_idx_c),
        .rf_rd_data1(rf_rd_data1_c), .rf_rd_data2(rf_rd_data2_c),
        .fu_add_a(fu_add_a_c), .fu_add_b(fu_add_b_c), .fu_add_c(fu_add_c_c),
        .fu_mul_a(fu_mul_a_c), .fu_mul_b(fu_mul_b_c), .fu_mul_c(fu_mul_c_c),
        .rf_wr_en(rf_wr_en_c), .rf_wr_vd(rf_wr_vd_c), .rf_wr_idx(rf_wr_idx_c),
        .rf_wr_mask(rf_wr_mask_c), .rf_wr_data(rf_wr_data_c), .done(done_c)
    );

    always @(posedge clk) begin
        if (init_rf) begin
            for (int r = 0; r < 32; r++)
                for (int e = 0; e < 32; e++)
                    rf_c[r][e] <= 32'(r * 16 + e);
        end else begin
            if (rf_rd_en_c) begin
                rf_rd_data1_c[0] <= rf_c[rf_rd_vs1_c][5'(int'(rf_rd_idx_c))];
                rf_rd_data2_c[0] <= rf_c[rf_rd_vs2_c][5'(int'(rf_rd_idx_c))];
            end
            if (rf_wr_en_c && rf_wr_mask_c[0])
                rf_c[rf_wr_vd_c][5'(int'(rf_wr_idx_c))] <= rf_wr_data_c[0];
        end
        add_p1_c[0] <= fu_add_a_c[0] + fu_add_b_c[0];
        add_p2_c    <= add_p1_c;
        fu_add_c_c  <= add_p2_c;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic set_cmd(input logic op, input logic [5:0] vl,
                           input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d);
        cmd_op  = op;
        cmd_vl  = vl;
        cmd_vs1 = s1;
        cmd_vs2 = s2;
        cmd_vd  = d;
    endtask

    initial begin
        int rd_cnt, wr_cnt, dn_cnt;
        logic [3:0] last_mask;

        rst = 1'b1; init_rf = 1'b1;
        cmd_valid_a = 1'b0; cmd_valid_b = 1'b0; cmd_valid_c = 1'b0;
        set_cmd(1'b0, 6'd0, 5'd0, 5'd0, 5'd0);
        repeat (3) cyc();
        rst = 1'b0; init_rf = 1'b0;
        cyc();

        // Reset state
        chk("rst_ready", 128'(cmd_ready_a), 128'(1));
        chk("rst_rd_en", 128'(rf_rd_en_a), 128'(0));
        chk("rst_wr_en", 128'(rf_wr_en_a), 128'(0));
        chk("rst_mask", 128'(rf_wr_mask_b), 128'(0));
        chk("rst_done", 128'(done_a), 128'(0));
        $display("step reset: checked idle outputs");

        // vl=4 add, fields change while busy (one accept only)
        set_cmd(1'b0, 6'd4, 5'd1, 5'd2, 5'd7);
        cmd_valid_a = 1'b1;
        chk("a_accept_ready", 128'(cmd_ready_a), 128'(1));
        for (int c = 1; c <= 9; c++) begin
            cyc();
            if (c == 1) set_cmd(1'b1, 6'd9, 5'd3, 5'd4, 5'd9);
            chk($sformatf("a_rd_en_c%0d", c), 128'(rf_rd_en_a), 128'(c >= 1 && c <= 4));
            if (c <= 4) begin
                chk($sformatf("a_rd_idx_c%0d", c), 128'(rf_rd_idx_a), 128'(c - 1));
                chk($sformatf("a_rd_vs1_c%0d", c), 128'(rf_rd_vs1_a), 128'(1));
            end
            chk($sformatf("a_wr_en_c%0d", c), 128'(rf_wr_en_a), 128'(c >= 3 && c <= 6));
            if (c >= 3 && c <= 6) begin
                chk($sformatf("a_wr_idx_c%0d", c), 128'(rf_wr_idx_a), 128'(c - 3));
                chk($sformatf("a_wr_data_c%0d", c), 128'(rf_wr_data_a), 128'(48 + 2 * (c - 3)));
                chk($sformatf("a_wr_vd_c%0d", c), 128'(rf_wr_vd_a), 128'(7));
            end
            chk($sformatf("a_done_c%0d", c), 128'(done_a), 128'(c == 6));
            chk($sformatf("a_ready_c%0d", c), 128'(cmd_ready_a), 128'(c >= 7));
            if (c == 6) cmd_valid_a = 1'b0;
            $display("step a_vl4 cycle %0d: rd_en=%0d wr_en=%0d done=%0d", c, rf_rd_en_a, rf_wr_en_a, done_a);
        end

        // vl=0: no beats, done the cycle after accept
        set_cmd(1'b0, 6'd0, 5'd1, 5'd2, 5'd11);
        cmd_valid_a = 1'b1;
        cyc();
        cmd_valid_a = 1'b0;
        chk("z_done_c1", 128'(done_a), 128'(1));
        chk("z_rd_en_c1", 128'(rf_rd_en_a), 128'(0));
        chk("z_wr_en_c1", 128'(rf_wr_en_a), 128'(0));
        chk("z_ready_c1", 128'(cmd_ready_a), 128'(1));
        cyc();
        chk("z_done_c2", 128'(done_a), 128'(0));
        chk("z_rd_en_c2", 128'(rf_rd_en_a), 128'(0));
        $display("step vl0: done pulse checked");

        // Reset mid-command: vl=8, rst on the cycle after the second read
        set_cmd(1'b0, 6'd8, 5'd1, 5'd2, 5'd10);
        cmd_valid_a = 1'b1;
        cyc();
        cmd_valid_a = 1'b0;
        cyc();
        chk("r_rd_idx_c2", 128'(rf_rd_idx_a), 128'(1));
        cyc();
        chk("r_wr_en_c3", 128'(rf_wr_en_a), 128'(1));
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("r_ready_c4", 128'(cmd_ready_a), 128'(1));
        chk("r_rd_en_c4", 128'(rf_rd_en_a), 128'(0));
        chk("r_mask_c4", 128'(rf_wr_mask_a), 128'(0));
        for (int c = 4; c <= 12; c++) begin
            if (c > 4) cyc();
            chk($sformatf("r_wr_en_c%0d", c), 128'(rf_wr_en_a), 128'(0));
            chk($sformatf("r_done_c%0d", c), 128'(done_a), 128'(0));
        end
        $display("step reset_mid: flush checked");

        // LANES=4 mul vl=6: two beats, masks 1111 then 0011
        set_cmd(1'b1, 6'd6, 5'd3, 5'd4, 5'd8);
        cmd_valid_b = 1'b1;
        cyc();
        cmd_valid_b = 1'b0;
        chk("b_rd_en_c1", 128'(rf_rd_en_b), 128'(1));
        chk("b_rd_idx_c1", 128'(rf_rd_idx_b), 128'(0));
        cyc();
        chk("b_rd_en_c2", 128'(rf_rd_en_b), 128'(1));
        chk("b_rd_idx_c2", 128'(rf_rd_idx_b), 128'(4));
        chk("b_mul_a_c2", 128'(fu_mul_a_b), {32'd51, 32'd50, 32'd49, 32'd48});
        chk("b_add_a_c2", 128'(fu_add_a_b), 128'(0));
        cyc();
        chk("b_rd_en_c3", 128'(rf_rd_en_b), 128'(0));
        chk("b_mul_a_c3", 128'(fu_mul_a_b), {32'd0, 32'd0, 32'd53, 32'd52});
        chk("b_wr_en_c3", 128'(rf_wr_en_b), 128'(1));
        chk("b_wr_idx_c3", 128'(rf_wr_idx_b), 128'(0));
        chk("b_wr_mask_c3", 128'(rf_wr_mask_b), 128'(4'b1111));
        chk("b_wr_data_c3", 128'(rf_wr_data_b), {32'd3417, 32'd3300, 32'd3185, 32'd3072});
        chk("b_done_c3", 128'(done_b), 128'(0));
        cyc();
        chk("b_wr_en_c4", 128'(rf_wr_en_b), 128'(1));
        chk("b_wr_idx_c4", 128'(rf_wr_idx_b), 128'(4));
        chk("b_wr_mask_c4", 128'(rf_wr_mask_b), 128'(4'b0011));
        chk("b_wr_data_c4", 128'(rf_wr_data_b), {32'd0, 32'd0, 32'd3657, 32'd3536});
        chk("b_done_c4", 128'(done_b), 128'(1));
        cyc();
        chk("b_done_c5", 128'(done_b), 128'(0));
        chk("b_ready_c5", 128'(cmd_ready_b), 128'(1));
        $display("step b_mul_vl6: beats checked");

        // vl above VLMAX is clamped: 40 -> 32 elements -> 8 beats of 4
        set_cmd(1'b0, 6'd40, 5'd1, 5'd2, 5'd9);
        cmd_valid_b = 1'b1;
        rd_cnt = 0; wr_cnt = 0; dn_cnt = 0; last_mask = '0;
        cyc();
        cmd_valid_b = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            if (rf_rd_en_b) rd_cnt++;
            if (rf_wr_en_b) wr_cnt++;
            if (done_b) begin
                dn_cnt++;
                last_mask = rf_wr_mask_b;
            end
            cyc();
        end
        chk("clamp_rd_beats", 128'(rd_cnt), 128'(8));
        chk("clamp_wr_beats", 128'(wr_cnt), 128'(8));
        chk("clamp_done_cnt", 128'(dn_cnt), 128'(1));
        chk("clamp_last_mask", 128'(last_mask), 128'(4'b1111));
        chk("clamp_ready", 128'(cmd_ready_b), 128'(1));
        $display("step clamp: rd=%0d wr=%0d done=%0d", rd_cnt, wr_cnt, dn_cnt);

        // FU_LAT=3, vd=vs1: sums written 4 cycles after each read
        set_cmd(1'b0, 6'd5, 5'd5, 5'd6, 5'd5);
        cmd_valid_c = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            cmd_valid_c = 1'b0;
            chk($sformatf("c_rd_en_c%0d", c), 128'(rf_rd_en_c), 128'(c <= 5));
            chk($sformatf("c_wr_en_c%0d", c), 128'(rf_wr_en_c), 128'(c >= 5 && c <= 9));
            if (c >= 5 && c <= 9) begin
                chk($sformatf("c_wr_idx_c%0d", c), 128'(rf_wr_idx_c), 128'(c - 5));
                chk($sformatf("c_wr_data_c%0d", c), 128'(rf_wr_data_c), 128'(176 + 2 * (c - 5)));
            end
            chk($sformatf("c_done_c%0d", c), 128'(done_c), 128'(c == 9));
            chk($sformatf("c_ready_c%0d", c), 128'(cmd_ready_c), 128'(c == 10));
            $display("step c_lat3 cycle %0d: rd_en=%0d wr_en=%0d done=%0d", c, rf_rd_en_c, rf_wr_en_c, done_c);
        end
        for (int e = 0; e < 5; e++)
            chk($sformatf("c_rf5_e%0d", e), 128'(rf_c[5][e]), 128'(176 + 2 * e));
        chk("c_rf5_e5_untouched", 128'(rf_c[5][5]), 128'(85));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/vector_issue_seq.md
VECTOR_ISSUE_SEQ -- requirements
Module: vector_issue_seq

Interface
REQ-001 SHALL have parameter LANES, default 1, setting FU lanes per op type and elements per beat.
REQ-002 SHALL have parameter FU_LAT, default 1, giving the fixed FU operand-to-result latency in cycles (>=1).
REQ-003 SHALL have parameter VLMAX, default 32, giving the maximum vector length in elements.
REQ-004 SHALL have these ports, clock and reset first (VLW = $clog2(VLMAX)+1):
- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid / cmd_ready  in / out  1  command handshake.
- cmd_op  in  1  0 = add, 1 = mul.
- cmd_vl  in  VLW  vector length, 0..VLMAX.
- cmd_vs1, cmd_vs2, cmd_vd  in  5 each  source and destination vector registers.
- rf_rd_en  out  1  register-file read strobe.
- rf_rd_vs1, rf_rd_vs2  out  5 each  read register numbers.
- rf_rd_idx  out  VLW  first element index of the beat.
- rf_rd_data1, rf_rd_data2  in  [LANES][32]  read data, valid one cycle after rf_rd_en.
- fu_add_a, fu_add_b  out  [LANES][32]  adder operands.
- fu_add_c  in  [LANES][32]  adder result.
- fu_mul_a, fu_mul_b  out  [LANES][32]  multiplier operands.
- fu_mul_c  in  [LANES][32]  multiplier result.
- rf_wr_en  out  1  write strobe.
- rf_wr_vd  out  5  destination register.
- rf_wr_idx  out  VLW  first element index of the beat.
- rf_wr_mask  out  LANES  per-lane write enable.
- rf_wr_data  out  [LANES][32]  write data.
- done  out  1  one-cycle pulse at command completion.

Function
REQ-005 SHALL accept a command only on a cycle where cmd_valid && cmd_ready; cmd_ready SHALL be high only in IDLE.
REQ-006 SHALL implement states IDLE, ISSUE and DRAIN: IDLE->ISSUE on accept with vl>0; ISSUE->DRAIN after the last read beat; DRAIN->IDLE on the cycle of the last write.
REQ-007 SHALL latch op, vl, vs1, vs2 and vd on accept; later cmd_* changes SHALL have no effect until the next accept.
REQ-008 SHALL issue B = ceil(vl/LANES) read beats on consecutive cycles, starting the cycle after accept, with rf_rd_idx = 0, LANES, 2*LANES, ...
REQ-009 SHALL set the beat mask bit i when rf_rd_idx+i < vl; the last beat SHALL be partial when vl is not a multiple of LANES.
REQ-010 SHALL drive rf_rd_data1/2 combinationally onto the selected FU's operands the cycle after the read; the unselected FU's operands and masked lanes SHALL be 0.
REQ-011 SHALL perform the write for read beat k exactly 1+FU_LAT cycles after that beat: rf_wr_en=1, idx and mask delayed from the read, rf_wr_vd = latched vd, rf_wr_data = fu_add_c or fu_mul_c per op.
REQ-012 SHALL assert done in the same cycle as the last write; cmd_ready SHALL return high the next cycle, so there is no command overlap.
REQ-013 SHALL, when vl==0, perform no reads or writes, pulse done the cycle after accept, and stay in IDLE.
REQ-014 SHALL treat cmd_vl > VLMAX as VLMAX.
REQ-015 SHALL permit vd equal to vs1 or vs2, since each element is read before its own write and later beats read other indices.
REQ-016 SHALL pass multiply results through unchanged; the FU alone defines the low-32-bit product.
REQ-017 SHALL hold rf_rd_en, rf_wr_en and done low outside active beats; idx, vd and data outputs are don't-care when their strobe is low.

Reset
REQ-018 SHALL on rst enter IDLE and drive cmd_ready=1, rf_rd_en=0, rf_wr_en=0, rf_wr_mask=0 and done=0 from the following cycle.
REQ-019 SHALL on rst mid-command flush all in-flight beats: no write and no done for the aborted command.

Structure
REQ-020 SHALL take the op enum (OP_ADD, OP_MUL), ELEN=32 and the register-number width from shared package vfu_pkg.
REQ-021 SHALL implement the 1+FU_LAT-deep valid/idx/mask delay line as sub-module vfu_beat_tracker, which rst clears.

Verification
REQ-022 SHALL cover: LANES=1, FU_LAT=1, add, vl=4, accept at cycle 0 -> reads at cycles 1..4, writes at cycles 3..6 with idx 0..3, done at cycle 6, cmd_ready high at cycle 7.
REQ-023 SHALL cover: LANES=4, mul, vl=6 -> two read beats, idx 0 then 4, write masks 1111 then 0011.
REQ-024 SHALL cover: vl=0 -> no rf_rd_en or rf_wr_en, done at cycle 1.
REQ-025 SHALL cover: cmd_valid held high with changing fields while busy -> exactly one accept, latched fields used.
REQ-026 SHALL cover: rst on the cycle after the second read of vl=8 -> no further rf_wr_en, no done, cmd_ready=1 the next cycle.
REQ-027 SHALL cover: FU_LAT=3, vd=vs1, vl=5, LANES=1 -> vs1 elements are read before being overwritten, and all writes equal the expected sums.
